// File: rtl/gearbox_tx_gen.sv
// gearbox_tx_gen: packs 66b blocks (2b sync header + 64b payload) into a DATA_W line stream.
// Latency: an accepted word appears on dout one cycle later; every 33rd output word carries only buffered residue.
// Backpressure: din_ready drops for one cycle after every 32 accepted words and never looks at din_valid.
//
// Optional feature: define GEARBOX_TX_STAT_EN to add the err_cnt port (saturating count of
// underflow cycles and misplaced sof); the datapath is identical with or without it.
//
// Ports:
//   clk, rst              single clock, asynchronous active-high reset
//   din[DATA_W]           payload word, block bit 0 in din[0]
//   hdr[2]                sync header, used only with word index 0 of a block
//   sof                   first-word marker, statistics only (alignment comes from the word index)
//   din_valid/din_ready   input handshake
//   dout[DATA_W]          line word, dout[0] transmitted first
//   dout_valid            dout carries a new line word this cycle
//   err_cnt[16]           error statistics (GEARBOX_TX_STAT_EN only)
module gearbox_tx_gen #(
  parameter int DATA_W = 32,
  parameter int WPB    = 64 / DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        hdr,
  input  logic              sof,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
`ifdef GEARBOX_TX_STAT_EN
  ,
  output logic [15:0]       err_cnt
`endif
);

  // Residue before a header word is at most DATA_W-2 bits and at most DATA_W bits before a
  // plain word, so residue plus the incoming bits always fits in two line words.
  localparam int         CAT_W   = 2 * DATA_W;
  localparam logic [5:0] LAST_PH = 6'd32;

  logic [5:0]        r_phase;
  logic [1:0]        r_widx;
  logic [6:0]        r_rlen;
  logic [DATA_W-1:0] r_res;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;

  logic              w_ready;
  logic              w_accept;
  logic              w_first;
  logic [CAT_W-1:0]  w_ext;
  logic [CAT_W-1:0]  w_cat;

  assign w_ready  = (r_phase != LAST_PH);
  assign w_accept = din_valid && w_ready;
  assign w_first  = (r_widx == 2'd0);

  // Header bits precede the payload on the line, so they sit below din.
  assign w_ext = w_first ? CAT_W'({din, hdr}) : CAT_W'(din);
  // Older residue bits go out first: new bits are stacked above them.
  assign w_cat = (w_ext << r_rlen) | CAT_W'(r_res);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase      <= '0;
      r_widx       <= '0;
      r_rlen       <= '0;
      r_res        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (!w_ready) begin
      // 32 words have built up exactly DATA_W spare bits; emit them and restart.
      r_dout       <= r_res;
      r_dout_valid <= 1'b1;
      r_res        <= '0;
      r_rlen       <= '0;
      r_phase      <= '0;
    end else if (w_accept) begin
      r_dout       <= w_cat[DATA_W-1:0];
      r_dout_valid <= 1'b1;
      r_res        <= w_cat[CAT_W-1:DATA_W];
      // Only a header word adds net bits (2); a plain word replaces what it pushes out.
      r_rlen       <= r_rlen + (w_first ? 7'd2 : 7'd0);
      r_phase      <= r_phase + 6'd1;
      r_widx       <= (r_widx == 2'(WPB - 1)) ? 2'd0 : r_widx + 2'd1;
    end else begin
      r_dout_valid <= 1'b0;
    end
  end

  assign din_ready  = w_ready;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

`ifdef GEARBOX_TX_STAT_EN
  logic [15:0] r_err;
  logic        w_err_evt;

  // Underflow and sof misplacement in the same cycle count as one event.
  assign w_err_evt = (w_ready && !din_valid) || (w_accept && (sof != w_first));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0;
    end else if (w_err_evt && (r_err != 16'hFFFF)) begin
      r_err <= r_err + 16'd1;
    end
  end

  assign err_cnt = r_err;
`else
  logic w_sof_unused;
  assign w_sof_unused = sof;
`endif

endmodule

// File: tb/tb_gearbox_tx_gen.sv
// tb_gearbox_tx_gen: drives three gearboxes (DATA_W 16/32/64) and checks them against a bitstream model.
// Latency: model expects each accepted word on dout one cycle later, residue words every 33rd output.
// Backpressure: source re-presents any word offered while din_ready is low.
module tb_gearbox_tx_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [63:0] din_a [3];
  logic [1:0]  hdr_a [3];
  logic        sof_a [3];
  logic        vld_a [3];

  logic        rdy0, rdy1, rdy2;
  logic        dv0, dv1, dv2;
  logic [15:0] dout0;
  logic [31:0] dout1;
  logic [63:0] dout2;
`ifdef GEARBOX_TX_STAT_EN
  logic [15:0] err0, err1, err2;
`endif

  gearbox_tx_gen #(.DATA_W(16)) u_g16 (
    .clk(clk), .rst(rst), .din(din_a[0][15:0]), .hdr(hdr_a[0]), .sof(sof_a[0]),
    .din_valid(vld_a[0]), .din_ready(rdy0), .dout(dout0), .dout_valid(dv0)
`ifdef GEARBOX_TX_STAT_EN
    , .err_cnt(err0)
`endif
  );

  gearbox_tx_gen #(.DATA_W(32)) u_g32 (
    .clk(clk), .rst(rst), .din(din_a[1][31:0]), .hdr(hdr_a[1]), .sof(sof_a[1]),
    .din_valid(vld_a[1]), .din_ready(rdy1), .dout(dout1), .dout_valid(dv1)
`ifdef GEARBOX_TX_STAT_EN
    , .err_cnt(err1)
`endif
  );

  gearbox_tx_gen #(.DATA_W(64)) u_g64 (
    .clk(clk), .rst(rst), .din(din_a[2]), .hdr(hdr_a[2]), .sof(sof_a[2]),
    .din_valid(vld_a[2]), .din_ready(rdy2), .dout(dout2), .dout_valid(dv2)
`ifdef GEARBOX_TX_STAT_EN
    , .err_cnt(err2)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic get_rdy(input int l);
    case (l)
      0:       return rdy0;
      1:       return rdy1;
      default: return rdy2;
    endcase
  endfunction

  function automatic logic get_dv(input int l);
    case (l)
      0:       return dv0;
      1:       return dv1;
      default: return dv2;
    endcase
  endfunction

  function automatic logic [63:0] get_dout(input int l);
    case (l)
      0:       return 64'(dout0);
      1:       return 64'(dout1);
      default: return dout2;
    endcase
  endfunction

`ifdef GEARBOX_TX_STAT_EN
  function automatic logic [63:0] get_err(input int l);
    case (l)
      0:       return 64'(err0);
      1:       return 64'(err1);
      default: return 64'(err2);
    endcase
  endfunction
  int m_err [3];
`endif

  // Reference: a FIFO of line bits per lane, fed by hdr+payload of accepted words and drained
  // DATA_W bits per valid output word. Ready is low for one cycle after each 32 accepts.
  bit          ring     [3][1024];
  int          wr_p     [3];
  int          rd_p     [3];
  int          m_widx   [3];
  int          acc_cnt  [3];
  bit          owe      [3];
  bit          exp_dv   [3];
  bit          was_flush[3];
  bit          acc_now  [3];
  logic [63:0] last_dout[3];

  bit en [3];
  bit gaps;
  int sof_pos;

  task automatic push_bit(input int l, input bit b);
    ring[l][wr_p[l] % 1024] = b;
    wr_p[l]++;
  endtask

  always @(negedge clk) begin
    int          w;
    logic [63:0] e;
    logic [63:0] d;
    bit          r;
    bit          acc;
    for (int l = 0; l < 3; l++) begin
      w = 16 << l;
      if (rst) begin
        wr_p[l] = 0; rd_p[l] = 0; m_widx[l] = 0; acc_cnt[l] = 0;
        owe[l] = 0; exp_dv[l] = 0; was_flush[l] = 0; acc_now[l] = 0;
        last_dout[l] = '0;
`ifdef GEARBOX_TX_STAT_EN
        m_err[l] = 0;
`endif
      end else begin
`ifdef GEARBOX_TX_STAT_EN
        check($sformatf("err_l%0d", l), get_err(l), 64'(m_err[l]));
`endif
        check($sformatf("dvld_l%0d", l), 64'(get_dv(l)), 64'(exp_dv[l]));
        d = get_dout(l);
        if (get_dv(l)) begin
          check($sformatf("avail_l%0d", l), 64'((wr_p[l] - rd_p[l]) >= w), 64'(1));
          e = '0;
          for (int i = 0; i < w; i++) begin
            if (rd_p[l] < wr_p[l]) begin
              e[i] = ring[l][rd_p[l] % 1024];
              rd_p[l]++;
            end
          end
          check($sformatf("dout_l%0d", l), d, e);
          last_dout[l] = d;
          if (was_flush[l]) check($sformatf("resid_l%0d", l), 64'(wr_p[l] - rd_p[l]), 64'(0));
        end else begin
          check($sformatf("hold_l%0d", l), d, last_dout[l]);
        end
        r = get_rdy(l);
        check($sformatf("rdy_l%0d", l), 64'(r), 64'(!owe[l]));
        acc = vld_a[l] && r;
`ifdef GEARBOX_TX_STAT_EN
        if ((r && !vld_a[l]) || (acc && (sof_a[l] != (m_widx[l] == 0))))
          if (m_err[l] < 65535) m_err[l]++;
`endif
        exp_dv[l]    = acc || !r;
        was_flush[l] = !r;
        if (!r) owe[l] = 0;
        if (acc) begin
          if (m_widx[l] == 0) begin
            push_bit(l, hdr_a[l][0]);
            push_bit(l, hdr_a[l][1]);
          end
          for (int i = 0; i < w; i++) push_bit(l, din_a[l][i]);
          m_widx[l] = (m_widx[l] + 1) % (64 / w);
          acc_cnt[l]++;
          if (acc_cnt[l] % 32 == 0) owe[l] = 1;
        end
        acc_now[l] = acc;
      end
    end
  end

  // Called at posedge+1: re-present a refused word, otherwise offer a new one (or a gap).
  task automatic drive_lane(input int l);
    if (!en[l]) begin
      vld_a[l] = 1'b0;
      sof_a[l] = 1'b0;
    end else if (vld_a[l] && !acc_now[l]) begin
      vld_a[l] = 1'b1;
    end else if (gaps && ($urandom_range(0, 7) == 0)) begin
      vld_a[l] = 1'b0;
    end else begin
      din_a[l] = {$urandom, $urandom};
      hdr_a[l] = 2'($urandom_range(0, 3));
      sof_a[l] = (m_widx[l] == sof_pos);
      vld_a[l] = 1'b1;
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      for (int l = 0; l < 3; l++) drive_lane(l);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int l = 0; l < 3; l++) begin
      vld_a[l] = 1'b0;
      sof_a[l] = 1'b0;
      en[l]    = 1'b0;
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n_low, n_low_ok, n_acc, n_dv;
    logic [63:0] e0;
    rst = 1'b1;
    gaps = 1'b0;
    sof_pos = 0;
    for (int l = 0; l < 3; l++) begin
      din_a[l] = '0; hdr_a[l] = '0; sof_a[l] = 1'b0; vld_a[l] = 1'b0; en[l] = 1'b0;
    end

    // Reset state
    #3;
    check("rst_dout32", 64'(dout1), 64'(0));
    check("rst_dvld32", 64'(dv1), 64'(0));
    check("rst_dout64", dout2, 64'(0));
    check("rst_rdy16", 64'(rdy0), 64'(1));
`ifdef GEARBOX_TX_STAT_EN
    check("rst_err32", get_err(1), 64'(0));
`endif
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Known block on the 32-bit lane
    din_a[1] = 64'h0000_0000_89AB_CDEF;
    hdr_a[1] = 2'b01;
    sof_a[1] = 1'b1;
    vld_a[1] = 1'b1;
    check("t030_rdy", 64'(rdy1), 64'(1));
    @(posedge clk);
    #1;
    check("t030_dout", 64'(dout1), 64'h26AF_37BD);
    check("t030_dvld", 64'(dv1), 64'(1));
    din_a[1] = 64'h0000_0000_0123_4567;
    sof_a[1] = 1'b0;
    @(posedge clk);
    #1;
    vld_a[1] = 1'b0;
    run(3);

    // 66 cycles of continuous input
    do_reset();
    en[1] = 1'b1;
    n_low = 0; n_low_ok = 0; n_acc = 0; n_dv = 0;
    for (int c = 1; c <= 66; c++) begin
      for (int l = 0; l < 3; l++) drive_lane(l);
      if (!rdy1) begin
        n_low++;
        if (c == 33 || c == 66) n_low_ok++;
      end
      if (vld_a[1] && rdy1) n_acc++;
      if (c > 1 && dv1) n_dv++;
      @(posedge clk);
      #1;
    end
    check("t031_low_cnt", 64'(n_low), 64'(2));
    check("t031_low_pos", 64'(n_low_ok), 64'(2));
    check("t031_accepted", 64'(n_acc), 64'(64));
    check("t031_dvld_cnt", 64'(n_dv), 64'(65));

    // Three-cycle underflow at phase 10
    do_reset();
    en[1] = 1'b1;
    run(10);
    en[1] = 1'b0;
`ifdef GEARBOX_TX_STAT_EN
    e0 = get_err(1);
`else
    e0 = '0;
`endif
    for (int k = 0; k < 3; k++) begin
      drive_lane(1);
      @(posedge clk);
      #1;
      check($sformatf("t033_dvld%0d", k), 64'(dv1), 64'(0));
      check($sformatf("t033_rdy%0d", k), 64'(rdy1), 64'(1));
    end
`ifdef GEARBOX_TX_STAT_EN
    check("t033_err", get_err(1), e0 + 64'd3);
`endif
    en[1] = 1'b1;
    run(60);

    // sof on word index 1 instead of 0
    do_reset();
    en[1] = 1'b1;
    sof_pos = 1;
`ifdef GEARBOX_TX_STAT_EN
    e0 = get_err(1);
`endif
    run(2);
`ifdef GEARBOX_TX_STAT_EN
    check("t034_err", get_err(1), e0 + 64'd2);
`endif
    run(20);
    sof_pos = 0;
    run(20);

    // Reset mid-block at phase 17
    do_reset();
    en[1] = 1'b1;
    run(17);
    #1;
    rst = 1'b1;
    en[1] = 1'b0;
    vld_a[1] = 1'b0;
    #1;
    check("t035_dout", 64'(dout1), 64'(0));
    check("t035_dvld", 64'(dv1), 64'(0));
    check("t035_rdy", 64'(rdy1), 64'(1));
`ifdef GEARBOX_TX_STAT_EN
    check("t035_err", get_err(1), 64'(0));
`endif
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    en[1] = 1'b1;
    run(1);
    check("t035_hdr", 64'(dout1[1:0]), 64'(hdr_a[1]));
    check("t035_hdr_vld", 64'(dv1), 64'(1));
    run(40);

    // Random traffic with gaps on all widths
    do_reset();
    for (int l = 0; l < 3; l++) en[l] = 1'b1;
    gaps = 1'b1;
    run(10000);
    for (int l = 0; l < 3; l++) en[l] = 1'b0;
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gearbox_tx_gen.md
GEARBOX_TX_GEN -- requirements
Module: gearbox_tx_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning input and output word width in bits; legal values 16, 32, 64.
REQ-002 SHALL have parameter WPB, default 64/DATA_W, meaning input words per 66b block; derived, not overridden.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port din  input  DATA_W  payload word; block bit 0 in din[0].
REQ-006 SHALL have port hdr  input  2  sync header; sampled only with the first word of a block.
REQ-007 SHALL have port sof  input  1  marks the first word of a 66b block.
REQ-008 SHALL have port din_valid  input  1  din/hdr/sof valid.
REQ-009 SHALL have port din_ready  output  1  gearbox accepts a word this cycle.
REQ-010 SHALL have port dout  output  DATA_W  line word; dout[0] transmitted first.
REQ-011 SHALL have port dout_valid  output  1  dout carries a new line word.
REQ-012 SHALL have port err_cnt  output  16  sof misalignment and underflow count; present only with GEARBOX_TX_STAT_EN.

Function
REQ-013 SHALL define the line bitstream as the concatenation of blocks, each block being hdr[0], hdr[1], then data bits 0..63; dout[i] of output word k SHALL equal stream bit DATA_W*k+i.
REQ-014 SHALL keep a phase counter 0..32; 33 output words carry exactly 32 input words for every legal DATA_W.
REQ-015 SHALL drive din_ready=1 for phase 0..31 and din_ready=0 for phase 32; din_ready SHALL depend on phase only, never on din_valid.
REQ-016 SHALL accept a word on a cycle with din_valid && din_ready; it SHALL then advance phase by one.
REQ-017 SHALL, at phase 32, advance phase to 0 unconditionally and output the DATA_W buffered residue bits.
REQ-018 SHALL, when din_valid=0 at phase 0..31 (underflow), hold phase, residue and word index, and drive dout_valid=0 on the next cycle.
REQ-019 SHALL register dout and dout_valid: a word accepted in cycle n SHALL produce its output word in cycle n+1 with dout_valid=1.
REQ-020 SHALL hold dout at its previous value whenever dout_valid=0.
REQ-021 SHALL carry residue bits between words in an internal register of at least DATA_W bits; residue length after phase p is 2*(blocks started) - DATA_W*(phase-32 stalls), reaching 0 after phase 32.
REQ-022 SHALL keep a word index 0..WPB-1 that advances on each accepted word and wraps to 0 after WPB-1; hdr SHALL be inserted only at word index 0.
REQ-023 SHALL ignore sof for datapath purposes; alignment SHALL be set by the word index alone, so a misplaced sof never shifts the stream.
REQ-024 SHALL treat din_valid asserted while din_ready=0 as no transfer; the word SHALL be presented again by the source.

Reset
REQ-025 SHALL, on rst assertion, asynchronously clear phase, word index, residue, dout, dout_valid, and err_cnt to 0.
REQ-026 SHALL, when rst is asserted mid-block, discard partial residue; the first word accepted after release SHALL be treated as word index 0 of a new block at phase 0.
REQ-027 SHALL drive din_ready=1 in the first cycle after rst release.

Configuration
REQ-028 SHALL, with macro GEARBOX_TX_STAT_EN defined, implement err_cnt as a saturating 16-bit counter incremented by 1 per cycle in which an underflow occurs or an accepted word has sof != (word index == 0); simultaneous events SHALL count once.
REQ-029 SHALL, without GEARBOX_TX_STAT_EN, omit the err_cnt port and all counter logic, with no change to datapath behaviour.

Verification
REQ-030 SHALL cover: DATA_W=32, hdr=2'b01, data 64'h0123456789ABCDEF, sof on word 0 -> first dout=32'h26AF37BD, dout_valid=1 one cycle after acceptance.
REQ-031 SHALL cover: DATA_W=32, continuous din_valid for 66 cycles -> din_ready low exactly in cycles 33 and 66, 64 words accepted, dout_valid high every cycle after the first.
REQ-032 SHALL cover: DATA_W=16 and 64, random blocks for 10000 cycles -> dout bitstream equals reference concatenation of REQ-013 bit-exact.
REQ-033 SHALL cover: din_valid=0 for 3 cycles at phase 10 -> phase holds, dout_valid=0 for 3 cycles, stream continuous afterwards, err_cnt=3 with GEARBOX_TX_STAT_EN.
REQ-034 SHALL cover: sof asserted on word index 1 -> stream unchanged, err_cnt increments by 2 (missing sof on word 0, extra sof on word 1).
REQ-035 SHALL cover: rst asserted at phase 17 mid-block -> dout=0, dout_valid=0, err_cnt=0 immediately; next accepted block output starts with its hdr at dout[1:0].
